// File: rtl/des_sbox_pbox_stage.sv
// DES f-function back end: (E ^ K) -> S-boxes -> P permutation.
// Bit 0 of every vector is DES bit 1 (the MSB).
// Two-deep valid/ready pipeline: an optional XOR register, then the result register.
module des_sbox_pbox_stage #(
  parameter int XOR_REG = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:47] expanded_in,
  input  logic [0:47] subkey_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:31] f_out
);

  // S1..S8 as 64-nibble ROMs, row-major (row 0 col 0 first), nibble MSB first.
  localparam logic [0:255] SBOX [0:7] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  // P permutation, converted to 0-based source indices into the S-box output.
  localparam logic [4:0] P_IDX [0:31] = '{
    5'd15, 5'd6,  5'd19, 5'd20, 5'd28, 5'd11, 5'd27, 5'd16,
    5'd0,  5'd14, 5'd22, 5'd25, 5'd4,  5'd17, 5'd30, 5'd9,
    5'd1,  5'd7,  5'd23, 5'd13, 5'd31, 5'd26, 5'd2,  5'd8,
    5'd18, 5'd12, 5'd29, 5'd5,  5'd21, 5'd10, 5'd3,  5'd24
  };

  logic [0:47] sp_in;   // E ^ K feeding the S-box layer
  logic        sp_adv;  // result register loads this cycle
  logic [0:31] s_val;   // concatenated S-box outputs
  logic [0:31] p_val;   // P(S(E ^ K))

  // ---- stage p1: optional E ^ K register ----
  if (XOR_REG != 0) begin : g_xor_reg
    logic        vld_p1;
    logic [0:47] x_p1;

    assign sp_adv   = vld_p1 && (!out_valid || out_ready);
    assign in_ready = !vld_p1 || sp_adv;
    assign sp_in    = x_p1;

    // Capture E ^ K on accept; empty the slot when it moves on with nothing behind it.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p1 <= 1'b0;
        x_p1   <= '0;
      end else if (in_valid && in_ready) begin
        vld_p1 <= 1'b1;
        x_p1   <= expanded_in ^ subkey_in;
      end else if (sp_adv) begin
        vld_p1 <= 1'b0;
      end
    end
  end else begin : g_xor_comb
    assign in_ready = !out_valid || out_ready;
    assign sp_adv   = in_valid && in_ready;
    assign sp_in    = expanded_in ^ subkey_in;
  end

  // S-box layer: row = {b0,b5}, col = {b1..b4}, ROM index = row*16 + col.
  for (genvar j = 0; j < 8; j++) begin : g_sbox
    logic [0:5] grp;
    logic [5:0] idx;
    assign grp                = sp_in[6*j +: 6];
    assign idx                = {grp[0], grp[5], grp[1:4]};
    assign s_val[4*j +: 4]    = SBOX[j][{idx, 2'b00} +: 4];
  end

  // P permutation is pure wiring.
  for (genvar i = 0; i < 32; i++) begin : g_pbox
    assign p_val[i] = s_val[P_IDX[i]];
  end

  // ---- stage p2: result register ----
  // Load a new result on advance; drop valid only when consumed with nothing arriving.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      f_out     <= '0;
    end else if (sp_adv) begin
      out_valid <= 1'b1;
      f_out     <= p_val;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_des_sbox_pbox_stage.sv
// Bench for des_sbox_pbox_stage: both XOR_REG builds side by side, a table of
// known vectors, directed stall/reset sequences, and a randomized scoreboard run.
module tb_des_sbox_pbox_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid1, in_ready1, out_valid1, out_ready1;
  logic [47:0] e1, k1;
  logic [31:0] f1;
  logic        in_valid0, in_ready0, out_valid0, out_ready0;
  logic [47:0] e0, k0;
  logic [31:0] f0;

  des_sbox_pbox_stage #(.XOR_REG(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .expanded_in(e1), .subkey_in(k1), .out_valid(out_valid1),
    .out_ready(out_ready1), .f_out(f1));

  des_sbox_pbox_stage #(.XOR_REG(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .expanded_in(e0), .subkey_in(k0), .out_valid(out_valid0),
    .out_ready(out_ready0), .f_out(f0));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference f(): FIPS 46-3 tables indexed [box][row][col], plus the 1-based P table.
  int SB [8][4][16] = '{
    '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
      '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
    '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
      '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
    '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
      '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
    '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
      '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
    '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
      '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
    '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
      '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
    '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
      '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
    '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
      '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}
  };
  int PT [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                  2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};

  function automatic logic [31:0] f_model(input logic [47:0] e, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s, f;
    int grp, row, col;
    x = e ^ k;
    s = '0;
    for (int j = 0; j < 8; j++) begin
      grp = int'((x >> (42 - 6*j)) & 48'h3F);
      row = (grp / 32) * 2 + (grp % 2);
      col = (grp / 2) % 16;
      s   = (s << 4) | 32'(SB[j][row][col]);
    end
    f = '0;
    for (int i = 0; i < 32; i++)
      f = (f << 1) | ((s >> (32 - PT[i])) & 32'd1);
    return f;
  endfunction

  // Scoreboard monitor: handshakes seen at negedge complete on the following posedge.
  logic [31:0] q1[$];
  logic [31:0] q0[$];
  logic        stall1 = 1'b0, stall0 = 1'b0;
  logic [31:0] held1 = '0, held0 = '0;

  always @(negedge clk) begin
    if (rst) begin
      q1.delete();
      q0.delete();
      stall1 <= 1'b0;
      stall0 <= 1'b0;
    end else begin
      if (stall1) begin
        chk("hold_valid1", 64'(out_valid1), 64'd1);
        chk("hold_f1", 64'(f1), 64'(held1));
      end
      if (stall0) begin
        chk("hold_valid0", 64'(out_valid0), 64'd1);
        chk("hold_f0", 64'(f0), 64'(held0));
      end
      if (out_valid1 && out_ready1) begin
        if (q1.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL spurious_out1: got f_out=%h, expected no output", f1);
        end else chk("data1", 64'(f1), 64'(q1.pop_front()));
      end
      if (out_valid0 && out_ready0) begin
        if (q0.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL spurious_out0: got f_out=%h, expected no output", f0);
        end else chk("data0", 64'(f0), 64'(q0.pop_front()));
      end
      if (in_valid1 && in_ready1) q1.push_back(f_model(e1, k1));
      if (in_valid0 && in_ready0) q0.push_back(f_model(e0, k0));
      stall1 <= out_valid1 && !out_ready1;
      stall0 <= out_valid0 && !out_ready0;
      held1  <= f1;
      held0  <= f0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] rnd48();
    return {16'($urandom()), 32'($urandom())};
  endfunction

  typedef struct {
    logic [47:0] e;
    logic [47:0] k;
    logic [31:0] f;
  } vec_t;

  vec_t tbl [8];
  logic [47:0] bp_e [3];
  logic [47:0] bp_k [3];
  int cnt, first, last, acc, del;

  initial begin
    tbl[0] = '{48'h7A15557A1555, 48'h1B02EFFC7072, 32'h234AA9BB};
    tbl[1] = '{48'h000000000000, 48'h000000000000, 32'hD8D8DBBC};
    tbl[2] = '{48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 32'hD8D8DBBC};
    tbl[3] = '{48'hFFFFFFFFFFFF, 48'h000000000000, 32'h38DBF9CB};
    for (int t = 4; t < 8; t++) begin
      tbl[t].e = rnd48();
      tbl[t].k = rnd48();
      tbl[t].f = f_model(tbl[t].e, tbl[t].k);
    end

    // Reset held with valid input offered
    rst = 1'b1;
    in_valid1 = 1'b1; e1 = tbl[0].e; k1 = tbl[0].k; out_ready1 = 1'b1;
    in_valid0 = 1'b1; e0 = tbl[0].e; k0 = tbl[0].k; out_ready0 = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_out_valid1", 64'(out_valid1), 64'd0);
    chk("rst_f_out1",     64'(f1),         64'd0);
    chk("rst_in_ready1",  64'(in_ready1),  64'd1);
    chk("rst_out_valid0", 64'(out_valid0), 64'd0);
    chk("rst_f_out0",     64'(f0),         64'd0);
    chk("rst_in_ready0",  64'(in_ready0),  64'd1);
    tick();
    rst = 1'b0;

    // Table vectors: latency 2 for the registered build, 1 for the combinational build
    for (int t = 0; t < 8; t++) begin
      in_valid1 = 1'b1; e1 = tbl[t].e; k1 = tbl[t].k; out_ready1 = 1'b1;
      in_valid0 = 1'b1; e0 = tbl[t].e; k0 = tbl[t].k; out_ready0 = 1'b1;
      tick();
      in_valid1 = 1'b0; in_valid0 = 1'b0;
      @(negedge clk);
      chk($sformatf("tbl%0d_lat1_early", t), 64'(out_valid1), 64'd0);
      chk($sformatf("tbl%0d_valid0", t),     64'(out_valid0), 64'd1);
      chk($sformatf("tbl%0d_f0", t),         64'(f0),         64'(tbl[t].f));
      tick();
      @(negedge clk);
      chk($sformatf("tbl%0d_valid1", t),     64'(out_valid1), 64'd1);
      chk($sformatf("tbl%0d_f1", t),         64'(f1),         64'(tbl[t].f));
      chk($sformatf("tbl%0d_valid0_drop", t),64'(out_valid0), 64'd0);
      tick();
    end

    // Back-to-back stream of 16 with out_ready held high
    cnt = 0; first = -1; last = -1;
    out_ready1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid1 = (i < 16);
      e1 = rnd48(); k1 = rnd48();
      @(negedge clk);
      if (i < 16) chk($sformatf("stream_in_ready_%0d", i), 64'(in_ready1), 64'd1);
      if (out_valid1) begin
        cnt++;
        if (first < 0) first = i;
        last = i;
      end
      tick();
    end
    chk("stream_count", 64'(cnt), 64'd16);
    chk("stream_contiguous", 64'(last - first + 1), 64'd16);

    // Backpressure: 5 stalled cycles with 3 inputs offered
    for (int b = 0; b < 3; b++) begin bp_e[b] = rnd48(); bp_k[b] = rnd48(); end
    in_valid1 = 1'b0; out_ready1 = 1'b0; acc = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid1 = (acc < 3);
      if (acc < 3) begin e1 = bp_e[acc]; k1 = bp_k[acc]; end
      @(negedge clk);
      if (c == 4) begin
        chk("bp_in_ready_full", 64'(in_ready1), 64'd0);
        chk("bp_head_f", 64'(f1), 64'(f_model(bp_e[0], bp_k[0])));
      end
      if (in_valid1 && in_ready1) acc++;
      tick();
    end
    chk("bp_accepts_while_stalled", 64'(acc), 64'd2);
    out_ready1 = 1'b1; del = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid1 = (acc < 3);
      if (acc < 3) begin e1 = bp_e[acc]; k1 = bp_k[acc]; end
      @(negedge clk);
      if (c == 0) chk("bp_release_in_ready", 64'(in_ready1), 64'd1);
      if (in_valid1 && in_ready1) acc++;
      if (out_valid1 && out_ready1) del++;
      tick();
      if (del == 3) break;
    end
    in_valid1 = 1'b0;
    chk("bp_delivered", 64'(del), 64'd3);

    // Reset with both stages full: nothing in flight may come out afterwards
    out_ready1 = 1'b0; out_ready0 = 1'b0;
    in_valid1 = 1'b1; e1 = rnd48(); k1 = rnd48();
    in_valid0 = 1'b1; e0 = rnd48(); k0 = rnd48();
    tick();
    e1 = rnd48(); k1 = rnd48();
    tick();
    in_valid1 = 1'b0; in_valid0 = 1'b0;
    @(negedge clk);
    chk("full_out_valid1", 64'(out_valid1), 64'd1);
    chk("full_in_ready1",  64'(in_ready1),  64'd0);
    chk("full_out_valid0", 64'(out_valid0), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst_out_valid1", 64'(out_valid1), 64'd0);
    chk("midrst_f_out1",     64'(f1),         64'd0);
    chk("midrst_in_ready1",  64'(in_ready1),  64'd1);
    chk("midrst_out_valid0", 64'(out_valid0), 64'd0);
    tick();
    rst = 1'b0; out_ready1 = 1'b1; out_ready0 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("no_stale1_%0d", c), 64'(out_valid1), 64'd0);
      chk($sformatf("no_stale0_%0d", c), 64'(out_valid0), 64'd0);
      tick();
    end

    // Random valid/ready toggling on both builds
    for (int c = 0; c < 10000; c++) begin
      in_valid1  = ($urandom_range(0, 3) != 0);
      out_ready1 = ($urandom_range(0, 2) != 0);
      e1 = rnd48(); k1 = rnd48();
      in_valid0  = ($urandom_range(0, 1) != 0);
      out_ready0 = ($urandom_range(0, 3) != 0);
      e0 = rnd48(); k0 = rnd48();
      tick();
    end
    in_valid1 = 1'b0; in_valid0 = 1'b0; out_ready1 = 1'b1; out_ready0 = 1'b1;
    repeat (5) tick();
    chk("drain_empty1", 64'(q1.size()), 64'd0);
    chk("drain_empty0", 64'(q0.size()), 64'd0);
    chk("drain_out_valid1", 64'(out_valid1), 64'd0);
    chk("drain_out_valid0", 64'(out_valid0), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
